reg_bus_master: RTL and testbench
=================================

# reg_bus_master

Bus-side master for the processor's 11-entry, 12-bit register file (R, row, cAT, cB, rnow, cATnow, cBnow, alphap, betap, gammap, Total). It accepts register-transfer requests from the control unit over a valid/ready handshake and sequences them into exactly-one-hot `read_en` and `write_en` strobes, the `datain` bus value and capture of `dataout`. It sits between the control FSM and the register file and is the only driver of the register-file enables.

## Interface
- `REG_COUNT`, 11: number of register-file entries; the width of both enable vectors.
- `REG_WIDTH`, 12: data width.
- `IDX_W`, 4: register index width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: reset is asynchronous and active-high.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the block can accept a request; high only in IDLE.
- `req_op`  in  2: 00 MOVE, 01 LOAD, 10 READ, 11 INC.
- `req_src`  in  IDX_W: source register index.
- `req_dst`  in  IDX_W: destination register index.
- `req_data`  in  REG_WIDTH: immediate value for LOAD.
- `read_en`  out  REG_COUNT: one-hot read select to the register file.
- `write_en`  out  REG_COUNT: one-hot write strobe to the register file.
- `bus_out`  out  REG_WIDTH: drives the register file's `datain`.
- `bus_in`  in  REG_WIDTH: the register file's `dataout`.
- `rsp_done`  out  1: one-cycle completion pulse.
- `rsp_err`  out  1: valid with `rsp_done`; the request was illegal.
- `rsp_data`  out  REG_WIDTH: the captured read value. It holds until the next capture.

## Operation
- States: IDLE, RD, WR, RESP.
- Accept: the request is accepted when `req_valid && req_ready`. `req_op`, `req_src`, `req_dst` and `req_data` are latched on acceptance.
- Legality: an index ≥ REG_COUNT is illegal, and so is an unsupported op (see Configuration).
  - An illegal request goes IDLE→RESP.
  - Both enables stay zero for the whole request.
  - `rsp_err` is 1 and the register file is untouched.
- MOVE: IDLE→RD→WR→RESP.
  - In RD, `read_en` = onehot(src); `bus_in` is captured into `hold` at the end of RD.
  - In WR, `write_en` = onehot(dst) and `bus_out` = `hold`.
- LOAD: IDLE→WR→RESP. In WR, `bus_out` = latched `req_data`. `req_src` is ignored.
- READ: IDLE→RD→RESP. `rsp_data` = `hold` from the cycle of RESP onward. `req_dst` is ignored.
- INC: as MOVE, but `bus_out` = `hold` + 1, modulo 2^REG_WIDTH (0xFFF→0x000).
- `rsp_data` is updated at every RD capture, including the capture done for MOVE and INC.
- Enable rules:
  - `read_en` is nonzero only in RD and `write_en` is nonzero only in WR.
  - Each is never multi-hot, and the two are never asserted in the same cycle.
  - `bus_out` is 0 outside WR.
- src == dst is legal (MOVE rewrites the same value; INC increments in place).
- RESP lasts one cycle, then the state returns to IDLE.

## Timing
- Reset (async, any state): state = IDLE; `read_en`, `write_en`, `bus_out`, `rsp_data` = 0; `rsp_done`, `rsp_err` = 0; `req_ready` = 1 once reset deasserts.
- Reset mid-transfer aborts the transfer with no write. If reset asserts during WR, the write may or may not land (asynchronous race); the bench does not check it.
- All outputs except `req_ready` are registered or are decoded from registered state only, so there is no combinational path from `req_*` to the enables.
- Latency, counted from the acceptance edge to the `rsp_done` cycle:
  - MOVE/INC: 3 cycles.
  - LOAD/READ: 2 cycles.
  - Illegal: 1 cycle.
- `req_ready` is 0 from the cycle after acceptance through RESP; back-to-back acceptance is possible in the cycle following RESP.
- The register file writes on the clock edge that ends WR; a read of that register is valid from the next cycle.

## Configuration
- `REG_BUS_INC_EN` defined: op 11 is INC as described, including the 12-bit incrementer.
- Not defined: op 11 is illegal (`rsp_err` = 1, no enables, 1-cycle latency) and the incrementer is not compiled in.

## Structure
- Package `reg_bus_pkg` holds:
  - op encodings (OP_MOVE, OP_LOAD, OP_READ, OP_INC);
  - the state encoding;
  - register index constants (IDX_R = 0 … IDX_TOTAL = 10);
  - REG_COUNT and REG_WIDTH defaults.
- Sub-module `onehot_dec`: IDX_W → REG_COUNT decoder with `in_range` flag output. It is instantiated twice (src and dst) and its `in_range` outputs feed the legality check.

## Test plan
- LOAD dst = 8 (betap), data 0x384 → one cycle with `write_en` = 0x100 and `bus_out` = 0x384; `rsp_done` two cycles after acceptance; `rsp_err` = 0.
- LOAD 0x0A5 to 1, then MOVE src = 1, dst = 10 → RD with `read_en` = 0x002; WR with `write_en` = 0x400 and `bus_out` = 0x0A5; READ 10 → `rsp_data` = 0x0A5.
- With `REG_BUS_INC_EN`: LOAD 0xFFF to 4, then INC 4→4 → READ 4 returns 0x000. Without the macro, op 11 → `rsp_err` = 1, enables stay 0, latency 1.
- Illegal index src = 11 (MOVE) and dst = 15 (LOAD) → `rsp_err` = 1, `read_en` = `write_en` = 0 throughout, register contents unchanged.
- `req_valid` held high for back-to-back requests → `req_ready` low during RD/WR/RESP; each request accepted exactly once; no enable overlap or multi-hot, checked every cycle by assertion.
- Reset asserted mid-RD of a MOVE → enables drop to 0 asynchronously; after release, state is IDLE, `req_ready` = 1, no `rsp_done` for the aborted request, and the destination register keeps its old value.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-file bus master.
// Holds op/state encodings, register indices and default sizes.
package reg_bus_pkg;

   localparam int REG_COUNT_DEF = 11;
   localparam int REG_WIDTH_DEF = 12;
   localparam int IDX_W_DEF     = 4;

   typedef enum logic [1:0] {
      OP_MOVE = 2'b00,
      OP_LOAD = 2'b01,
      OP_READ = 2'b10,
      OP_INC  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam int IDX_R      = 0;
   localparam int IDX_ROW    = 1;
   localparam int IDX_CAT    = 2;
   localparam int IDX_CB     = 3;
   localparam int IDX_RNOW   = 4;
   localparam int IDX_CATNOW = 5;
   localparam int IDX_CBNOW  = 6;
   localparam int IDX_ALPHAP = 7;
   localparam int IDX_BETAP  = 8;
   localparam int IDX_GAMMAP = 9;
   localparam int IDX_TOTAL  = 10;

endpackage

// File: rtl/onehot_dec.sv
// Register index to one-hot decoder with range flag.
// Ports: idx in; onehot out (zero when out of range); in_range out.
module onehot_dec
   import reg_bus_pkg::*;
#(
   parameter int IDX_W = IDX_W_DEF,
   parameter int N     = REG_COUNT_DEF
) (
   input  logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot,
   output logic             in_range
);

   always_comb begin
      onehot   = '0;
      in_range = (int'(idx) < N);
      for (int i = 0; i < N; i++) begin
         if (int'(idx) == i) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/reg_bus_master.sv
// Sequences register-transfer requests into one-hot read/write strobes.
// Ports: clk, reset (async high); req_* handshake in; read_en/write_en,
// bus_out to the register file; bus_in from it; rsp_done/err/data out.
// Build option: REG_BUS_INC_EN enables op 11 (INC); otherwise it is illegal.
module reg_bus_master
   import reg_bus_pkg::*;
#(
   parameter int REG_COUNT = REG_COUNT_DEF,
   parameter int REG_WIDTH = REG_WIDTH_DEF,
   parameter int IDX_W     = IDX_W_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_op,
   input  logic [IDX_W-1:0]     req_src,
   input  logic [IDX_W-1:0]     req_dst,
   input  logic [REG_WIDTH-1:0] req_data,
   output logic [REG_COUNT-1:0] read_en,
   output logic [REG_COUNT-1:0] write_en,
   output logic [REG_WIDTH-1:0] bus_out,
   input  logic [REG_WIDTH-1:0] bus_in,
   output logic                 rsp_done,
   output logic                 rsp_err,
   output logic [REG_WIDTH-1:0] rsp_data
);

   state_e                 state_q, state_d;
   op_e                    op_q, op_d;
   logic [REG_COUNT-1:0]   src_oh_q, src_oh_d;
   logic [REG_COUNT-1:0]   dst_oh_q, dst_oh_d;
   logic [REG_WIDTH-1:0]   data_q, data_d;
   logic [REG_WIDTH-1:0]   hold_q, hold_d;
   logic                   err_q, err_d;

   op_e                    req_op_e;
   logic [REG_COUNT-1:0]   src_oh, dst_oh;
   logic                   src_ok, dst_ok;
   logic                   legal;
   logic                   accept;
   logic [REG_WIDTH-1:0]   wr_data;

   assign req_op_e = op_e'(req_op);
   assign accept   = req_valid && req_ready;

   onehot_dec #(.IDX_W(IDX_W), .N(REG_COUNT)) u_src_dec (
      .idx      (req_src),
      .onehot   (src_oh),
      .in_range (src_ok)
   );

   onehot_dec #(.IDX_W(IDX_W), .N(REG_COUNT)) u_dst_dec (
      .idx      (req_dst),
      .onehot   (dst_oh),
      .in_range (dst_ok)
   );

   // Only the indices an op actually uses take part in legality.
   always_comb begin
      legal = 1'b0;
      unique case (req_op_e)
         OP_MOVE: legal = src_ok & dst_ok;
         OP_LOAD: legal = dst_ok;
         OP_READ: legal = src_ok;
`ifdef REG_BUS_INC_EN
         OP_INC:  legal = src_ok & dst_ok;
`else
         OP_INC:  legal = 1'b0;
`endif
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MOVE;
         src_oh_q <= '0;
         dst_oh_q <= '0;
         data_q   <= '0;
         hold_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         src_oh_q <= src_oh_d;
         dst_oh_q <= dst_oh_d;
         data_q   <= data_d;
         hold_q   <= hold_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!legal)                  state_d = ST_RESP;
               else if (req_op_e == OP_LOAD) state_d = ST_WR;
               else                         state_d = ST_RD;
            end
         end
         ST_RD:   state_d = (op_q == OP_READ) ? ST_RESP : ST_WR;
         ST_WR:   state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latch and read capture; hold doubles as rsp_data.
   always_comb begin
      op_d     = op_q;
      src_oh_d = src_oh_q;
      dst_oh_d = dst_oh_q;
      data_d   = data_q;
      err_d    = err_q;
      hold_d   = hold_q;
      if (accept) begin
         op_d     = req_op_e;
         src_oh_d = legal ? src_oh : '0;
         dst_oh_d = legal ? dst_oh : '0;
         data_d   = req_data;
         err_d    = ~legal;
      end
      if (state_q == ST_RD) hold_d = bus_in;
   end

   always_comb begin
      wr_data = hold_q;
      unique case (op_q)
         OP_LOAD: wr_data = data_q;
`ifdef REG_BUS_INC_EN
         OP_INC:  wr_data = hold_q + 1'b1;
`endif
         default: wr_data = hold_q;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      read_en   = '0;
      write_en  = '0;
      bus_out   = '0;
      rsp_done  = 1'b0;
      rsp_err   = 1'b0;
      unique case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_RD:   read_en = src_oh_q;
         ST_WR: begin
            write_en = dst_oh_q;
            bus_out  = wr_data;
         end
         ST_RESP: begin
            rsp_done = 1'b1;
            rsp_err  = err_q;
         end
         default: ;
      endcase
   end

   assign rsp_data = hold_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a behavioural register file.
// Checks strobes, latency, error flag, data path and async reset abort.
module tb_reg_bus_master;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [3:0]  req_src;
   logic [3:0]  req_dst;
   logic [11:0] req_data;
   logic [10:0] read_en;
   logic [10:0] write_en;
   logic [11:0] bus_out;
   logic [11:0] bus_in;
   logic        rsp_done;
   logic        rsp_err;
   logic [11:0] rsp_data;

   int errors = 0;
   int checks = 0;

   logic [11:0] mem [11];

   int          lat;
   logic        got_done;
   logic        got_err;
   logic [10:0] rd_seen;
   logic [10:0] wr_seen;
   logic [11:0] wr_bus;
   int          wr_cyc;
   logic [11:0] rsp_at_done;
   int          acc_cnt = 0;
   int          done_cnt = 0;

   reg_bus_master dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .req_data  (req_data),
      .read_en   (read_en),
      .write_en  (write_en),
      .bus_out   (bus_out),
      .bus_in    (bus_in),
      .rsp_done  (rsp_done),
      .rsp_err   (rsp_err),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int i = 0; i < 11; i++) begin
         if (write_en[i]) mem[i] <= bus_out;
      end
   end

   always_comb begin
      bus_in = '0;
      for (int i = 0; i < 11; i++) begin
         if (read_en[i]) bus_in = bus_in | mem[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (req_valid && req_ready && !reset) acc_cnt++;
      if (rsp_done) done_cnt++;
      chk("rd_onehot0", 32'($onehot0(read_en)), 1);
      chk("wr_onehot0", 32'($onehot0(write_en)), 1);
      chk("no_overlap", 32'((read_en != 0) && (write_en != 0)), 0);
      if (write_en == 0) chk("bus_idle_zero", 32'(bus_out), 0);
      if (read_en != 0 || write_en != 0 || rsp_done)
         chk("ready_busy_low", 32'(req_ready), 0);
   end

   task automatic do_req(input logic [1:0] op, input logic [3:0] src,
                         input logic [3:0] dst, input logic [11:0] data);
      chk("ready_before_req", 32'(req_ready), 1);
      req_valid = 1'b1;
      req_op    = op;
      req_src   = src;
      req_dst   = dst;
      req_data  = data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat      = 0;
      got_done = 1'b0;
      got_err  = 1'b0;
      rd_seen  = '0;
      wr_seen  = '0;
      wr_bus   = '0;
      wr_cyc   = 0;
      rsp_at_done = '0;
      for (int c = 1; c <= 6 && !got_done; c++) begin
         if (read_en != 0) rd_seen = rd_seen | read_en;
         if (write_en != 0) begin
            wr_seen = wr_seen | write_en;
            wr_bus  = bus_out;
            wr_cyc++;
         end
         if (rsp_done) begin
            got_done    = 1'b1;
            lat         = c;
            got_err     = rsp_err;
            rsp_at_done = rsp_data;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      chk("done_seen", 32'(got_done), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_src   = '0;
      req_dst   = '0;
      req_data  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_read_en", 32'(read_en), 0);
      chk("rst_write_en", 32'(write_en), 0);
      chk("rst_bus_out", 32'(bus_out), 0);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      chk("rst_rsp_done", 32'(rsp_done), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      reset = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready), 1);

      // LOAD betap
      do_req(2'b01, 4'd0, 4'd8, 12'h384);
      chk("load_lat", 32'(lat), 2);
      chk("load_err", 32'(got_err), 0);
      chk("load_wen", 32'(wr_seen), 'h100);
      chk("load_bus", 32'(wr_bus), 'h384);
      chk("load_wcyc", 32'(wr_cyc), 1);
      chk("load_ren", 32'(rd_seen), 0);
      chk("load_mem", 32'(mem[8]), 'h384);

      // LOAD then MOVE 1 -> 10, READ back
      do_req(2'b01, 4'd0, 4'd1, 12'h0A5);
      do_req(2'b00, 4'd1, 4'd10, 12'h000);
      chk("move_lat", 32'(lat), 3);
      chk("move_err", 32'(got_err), 0);
      chk("move_ren", 32'(rd_seen), 'h002);
      chk("move_wen", 32'(wr_seen), 'h400);
      chk("move_bus", 32'(wr_bus), 'h0A5);
      do_req(2'b10, 4'd10, 4'd0, 12'h000);
      chk("read_lat", 32'(lat), 2);
      chk("read_ren", 32'(rd_seen), 'h400);
      chk("read_wen", 32'(wr_seen), 0);
      chk("read_data_resp", 32'(rsp_at_done), 'h0A5);
      chk("read_data_hold", 32'(rsp_data), 'h0A5);

      // INC 4 -> 4 from 0xFFF
      do_req(2'b01, 4'd0, 4'd4, 12'hFFF);
      do_req(2'b11, 4'd4, 4'd4, 12'h000);
`ifdef REG_BUS_INC_EN
      chk("inc_lat", 32'(lat), 3);
      chk("inc_err", 32'(got_err), 0);
      chk("inc_ren", 32'(rd_seen), 'h010);
      chk("inc_wen", 32'(wr_seen), 'h010);
      chk("inc_bus", 32'(wr_bus), 'h000);
      do_req(2'b10, 4'd4, 4'd0, 12'h000);
      chk("inc_readback", 32'(rsp_data), 'h000);
`else
      chk("inc_off_lat", 32'(lat), 1);
      chk("inc_off_err", 32'(got_err), 1);
      chk("inc_off_ren", 32'(rd_seen), 0);
      chk("inc_off_wen", 32'(wr_seen), 0);
      do_req(2'b10, 4'd4, 4'd0, 12'h000);
      chk("inc_off_readback", 32'(rsp_data), 'hFFF);
`endif

      // Illegal indices
      do_req(2'b01, 4'd0, 4'd2, 12'h123);
      do_req(2'b00, 4'd11, 4'd2, 12'h000);
      chk("ill_src_lat", 32'(lat), 1);
      chk("ill_src_err", 32'(got_err), 1);
      chk("ill_src_ren", 32'(rd_seen), 0);
      chk("ill_src_wen", 32'(wr_seen), 0);
      do_req(2'b01, 4'd0, 4'd15, 12'h5A5);
      chk("ill_dst_lat", 32'(lat), 1);
      chk("ill_dst_err", 32'(got_err), 1);
      chk("ill_dst_wen", 32'(wr_seen), 0);
      chk("ill_mem2", 32'(mem[2]), 'h123);
      chk("ill_mem10", 32'(mem[10]), 'h0A5);

      // Back-to-back with req_valid held high
      acc_cnt  = 0;
      done_cnt = 0;
      req_op    = 2'b01;
      req_src   = 4'd0;
      req_dst   = 4'd5;
      req_data  = 12'h111;
      req_valid = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("b2b_accepts", 32'(acc_cnt), 2);
      chk("b2b_dones", 32'(done_cnt), 2);
      chk("b2b_mem5", 32'(mem[5]), 'h111);

      // Reset mid-RD of a MOVE
      do_req(2'b01, 4'd0, 4'd6, 12'h777);
      do_req(2'b01, 4'd0, 4'd7, 12'h222);
      done_cnt  = 0;
      req_op    = 2'b00;
      req_src   = 4'd6;
      req_dst   = 4'd7;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("abort_in_rd", 32'(read_en), 'h040);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_ren", 32'(read_en), 0);
      chk("abort_wen", 32'(write_en), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort_ready", 32'(req_ready), 1);
      chk("abort_rsp_data", 32'(rsp_data), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 0);
      chk("abort_mem7", 32'(mem[7]), 'h222);
      do_req(2'b10, 4'd7, 4'd0, 12'h000);
      chk("abort_readback", 32'(rsp_data), 'h222);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
